pipe_stall_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RV32 pipeline. It generates per-stage enable/flush for PC, IF_ID, ID_EX, EX_MEM and MEM_WB. It resolves load-use hazards, taken branches/jumps from EX, and multi-cycle bridge accesses from MEM through a req/ack handshake with timeout. Zero-wait slaves (bus_ack tied 1) keep today's single-cycle MEM timing.

---
 rtl/pipe_stall_ctrl_pkg.sv | 28 ++
 rtl/pipe_stall_ctrl_if.sv | 40 ++++
 rtl/pipe_bus_timer.sv | 30 +++
 rtl/pipe_stall_ctrl.sv | 158 +++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        PSC_RUN = 2'd0,
        PSC_LD  = 2'd1,
        PSC_BUS = 2'd2
    } psc_state_t;

    // Instruction word loaded by flushed pipeline registers (addi x0,x0,0).
    localparam logic [31:0] PSC_NOP = 32'h0000_0013;

    localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

    // A load in EX whose destination is read by the instruction in ID.
    function automatic logic load_use_hazard(
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic [1:0] rf_re,
        input logic [4:0] wr,
        input logic       rf_we,
        input logic       is_load
    );
        return is_load & rf_we & (wr != 5'd0) &
               ((rf_re[0] & (rs1 == wr)) | (rf_re[1] & (rs2 == wr)));
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard inputs, stage controls and bridge handshake of the stall sequencer.
interface pipe_stall_ctrl_if;

    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [1:0]  id_rf_re;
    logic [4:0]  ex_wr;
    logic        ex_rf_we;
    logic        ex_is_load;
    logic        ex_br_taken;
    logic        mem_acc;
    logic        bus_ack;
    logic        bus_req;
    logic        pc_en;
    logic        if_id_en;
    logic        if_id_flush;
    logic        id_ex_en;
    logic        id_ex_flush;
    logic        ex_mem_en;
    logic        mem_wb_flush;
    logic        bus_err;
    logic [31:0] stall_cnt;

    // Pipeline / bridge side.
    modport master (
        output id_rs1, id_rs2, id_rf_re, ex_wr, ex_rf_we, ex_is_load,
               ex_br_taken, mem_acc, bus_ack,
        input  bus_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mem_en, mem_wb_flush, bus_err, stall_cnt
    );

    // Sequencer side.
    modport slave (
        input  id_rs1, id_rs2, id_rf_re, ex_wr, ex_rf_we, ex_is_load,
               ex_br_taken, mem_acc, bus_ack,
        output bus_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mem_en, mem_wb_flush, bus_err, stall_cnt
    );

endinterface

// File: rtl/pipe_bus_timer.sv
// Counts cycles spent waiting on the bridge; expire flags the last allowed cycle.
module pipe_bus_timer #(
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] count;

    // Wait counter: cleared on exit from the wait, advanced while waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (count == LAST);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles,
// branch flushes and bridge wait states with timeout.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int LU_STALL = 1,
    parameter int TO_W     = 8,
    parameter int TIMEOUT  = 255
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    pipe_stall_ctrl_if.slave  ctl
);

    localparam logic [1:0] LU_LOAD = 2'(LU_STALL - 1);

    psc_state_t  state, state_nxt;
    psc_state_t  resume, resume_nxt;
    logic [1:0]  lu_cnt, lu_cnt_nxt;
    logic [31:0] stall_cnt;
    logic        lu_hz, bus_stall, release_bus;
    logic        timer_clr, timer_inc, timer_expire;
    psc_state_t  eff_state;
    logic        bus_req, pc_en, if_id_en, if_id_flush, id_ex_en;
    logic        id_ex_flush, ex_mem_en, mem_wb_flush, bus_err;

    assign lu_hz = load_use_hazard(ctl.id_rs1, ctl.id_rs2, ctl.id_rf_re,
                                   ctl.ex_wr, ctl.ex_rf_we, ctl.ex_is_load);
    assign bus_stall   = ctl.mem_acc & ~ctl.bus_ack;
    assign release_bus = ctl.bus_ack | timer_expire;

    pipe_bus_timer #(.TO_W(TO_W), .TIMEOUT(TIMEOUT)) u_timer (
        .clk    (cpu_clk),
        .rst    (cpu_rst),
        .clr    (timer_clr),
        .inc    (timer_inc),
        .expire (timer_expire)
    );

    // State, resume point and load-use bubble counter.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state  <= PSC_RUN;
            resume <= PSC_RUN;
            lu_cnt <= 2'd0;
        end else begin
            state  <= state_nxt;
            resume <= resume_nxt;
            lu_cnt <= lu_cnt_nxt;
        end
    end

    // Next state and stage controls; a released bus wait behaves like the resume state.
    always_comb begin
        bus_req      = ctl.mem_acc;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_en    = 1'b1;
        mem_wb_flush = 1'b0;
        bus_err      = 1'b0;
        state_nxt    = state;
        resume_nxt   = resume;
        lu_cnt_nxt   = lu_cnt;
        timer_clr    = 1'b0;
        timer_inc    = 1'b0;
        eff_state    = state;

        if (state == PSC_BUS) begin
            if (release_bus) begin
                timer_clr = 1'b1;
                bus_err   = ~ctl.bus_ack;
                eff_state = resume;
                state_nxt = resume;
            end else begin
                timer_inc    = 1'b1;
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_en    = 1'b0;
                mem_wb_flush = 1'b1;
            end
        end

        if (state != PSC_BUS || release_bus) begin
            if (bus_stall && state != PSC_BUS) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_en    = 1'b0;
                mem_wb_flush = 1'b1;
                state_nxt    = PSC_BUS;
                resume_nxt   = state;
            end else if (ctl.ex_br_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                lu_cnt_nxt  = 2'd0;
                state_nxt   = PSC_RUN;
            end else if (eff_state == PSC_LD) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
                if (lu_cnt <= 2'd1) begin
                    lu_cnt_nxt = 2'd0;
                    state_nxt  = PSC_RUN;
                end else begin
                    lu_cnt_nxt = lu_cnt - 2'd1;
                    state_nxt  = PSC_LD;
                end
            end else if (lu_hz) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
                if (LU_LOAD != 2'd0) begin
                    lu_cnt_nxt = LU_LOAD;
                    state_nxt  = PSC_LD;
                end else begin
                    state_nxt  = PSC_RUN;
                end
            end
        end

        if (cpu_rst) begin
            bus_req      = 1'b0;
            pc_en        = 1'b1;
            if_id_en     = 1'b1;
            if_id_flush  = 1'b0;
            id_ex_en     = 1'b1;
            id_ex_flush  = 1'b0;
            ex_mem_en    = 1'b1;
            mem_wb_flush = 1'b0;
            bus_err      = 1'b0;
        end
    end

    // Saturating count of cycles in which the PC is held.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            stall_cnt <= 32'd0;
        end else if (!pc_en && stall_cnt != STALL_CNT_MAX) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign ctl.bus_req      = bus_req;
    assign ctl.pc_en        = pc_en;
    assign ctl.if_id_en     = if_id_en;
    assign ctl.if_id_flush  = if_id_flush;
    assign ctl.id_ex_en     = id_ex_en;
    assign ctl.id_ex_flush  = id_ex_flush;
    assign ctl.ex_mem_en    = ex_mem_en;
    assign ctl.mem_wb_flush = mem_wb_flush;
    assign ctl.bus_err      = bus_err;
    assign ctl.stall_cnt    = stall_cnt;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: dut_a uses LU_STALL=1/TIMEOUT=255,
// dut_b uses LU_STALL=3/TIMEOUT=4.
module tb_pipe_stall_ctrl;

    logic cpu_clk = 1'b0;
    logic rst_a, rst_b;
    int   total = 0;
    int   bad   = 0;

    always #5 cpu_clk = ~cpu_clk;

    pipe_stall_ctrl_if if_a ();
    pipe_stall_ctrl_if if_b ();

    pipe_stall_ctrl #(.LU_STALL(1), .TO_W(8), .TIMEOUT(255)) dut_a (
        .cpu_clk (cpu_clk),
        .cpu_rst (rst_a),
        .ctl     (if_a.slave)
    );

    pipe_stall_ctrl #(.LU_STALL(3), .TO_W(8), .TIMEOUT(4)) dut_b (
        .cpu_clk (cpu_clk),
        .cpu_rst (rst_b),
        .ctl     (if_b.slave)
    );

    task automatic drive(input bit sel_b, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [1:0] re, input logic [4:0] wr, input logic we,
                         input logic ld, input logic br, input logic acc, input logic ack);
        if (sel_b) begin
            if_b.id_rs1 = rs1; if_b.id_rs2 = rs2; if_b.id_rf_re = re; if_b.ex_wr = wr;
            if_b.ex_rf_we = we; if_b.ex_is_load = ld; if_b.ex_br_taken = br;
            if_b.mem_acc = acc; if_b.bus_ack = ack;
        end else begin
            if_a.id_rs1 = rs1; if_a.id_rs2 = rs2; if_a.id_rf_re = re; if_a.ex_wr = wr;
            if_a.ex_rf_we = we; if_a.ex_is_load = ld; if_a.ex_br_taken = br;
            if_a.mem_acc = acc; if_a.bus_ack = ack;
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        rst_b = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge cpu_clk); @(negedge cpu_clk); #1;
        total++; if (if_a.bus_req !== 1'b0) begin bad++; $display("FAIL reset_bus_req: got %b want 0", if_a.bus_req); end
        total++; if (if_a.pc_en !== 1'b1 || if_a.ex_mem_en !== 1'b1) begin bad++; $display("FAIL reset_en: got pc_en=%b ex_mem_en=%b want 1 1", if_a.pc_en, if_a.ex_mem_en); end
        total++; if (if_a.mem_wb_flush !== 1'b0) begin bad++; $display("FAIL reset_flush: got %b want 0", if_a.mem_wb_flush); end
        total++; if (if_a.stall_cnt !== 32'd0 || if_b.stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_stall_cnt: got %0d/%0d want 0/0", if_a.stall_cnt, if_b.stall_cnt); end
        @(negedge cpu_clk);
        drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        rst_a = 1'b0;
        rst_b = 1'b0;
    endtask

    task automatic test_load_use();
        // ld x5 in EX, add x6,x5,x1 in ID
        @(negedge cpu_clk);
        drive(1'b0, 5'd5, 5'd1, 2'b11, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); #1;
        total++; if (if_a.pc_en !== 1'b0 || if_a.if_id_en !== 1'b0) begin bad++; $display("FAIL lu_hold: got pc_en=%b if_id_en=%b want 0 0", if_a.pc_en, if_a.if_id_en); end
        total++; if (if_a.id_ex_flush !== 1'b1 || if_a.id_ex_en !== 1'b1) begin bad++; $display("FAIL lu_bubble: got flush=%b en=%b want 1 1", if_a.id_ex_flush, if_a.id_ex_en); end
        @(negedge cpu_clk);
        drive(1'b0, 5'd5, 5'd1, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); #1;
        total++; if (if_a.pc_en !== 1'b1 || if_a.id_ex_flush !== 1'b0 || if_a.bus_req !== 1'b1) begin bad++; $display("FAIL lu_after: got pc_en=%b flush=%b req=%b want 1 0 1", if_a.pc_en, if_a.id_ex_flush, if_a.bus_req); end
        total++; if (if_a.stall_cnt !== 32'd1) begin bad++; $display("FAIL lu_stall_cnt: got %0d want 1", if_a.stall_cnt); end
        // load to x0 never hazards
        @(negedge cpu_clk);
        drive(1'b0, 5'd0, 5'd0, 2'b01, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); #1;
        total++; if (if_a.pc_en !== 1'b1) begin bad++; $display("FAIL lu_x0: got pc_en=%b want 1", if_a.pc_en); end
        // rs2 matches but rs2 not read
        @(negedge cpu_clk);
        drive(1'b0, 5'd3, 5'd7, 2'b01, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); #1;
        total++; if (if_a.pc_en !== 1'b1) begin bad++; $display("FAIL lu_re_mask: got pc_en=%b want 1", if_a.pc_en); end
        // rs2 matches and is read
        @(negedge cpu_clk);
        drive(1'b0, 5'd3, 5'd7, 2'b10, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); #1;
        total++; if (if_a.pc_en !== 1'b0) begin bad++; $display("FAIL lu_rs2: got pc_en=%b want 0", if_a.pc_en); end
        @(negedge cpu_clk);
        drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); #1;
        total++; if (if_a.stall_cnt !== 32'd2) begin bad++; $display("FAIL lu_stall_cnt2: got %0d want 2", if_a.stall_cnt); end
    endtask

    task automatic test_branch();
        @(negedge cpu_clk);
        drive(1'b0, 5'd5, 5'd1, 2'b11, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1); #1;
        total++; if (if_a.pc_en !== 1'b1 || if_a.if_id_en !== 1'b1) begin bad++; $display("FAIL br_en: got pc_en=%b if_id_en=%b want 1 1", if_a.pc_en, if_a.if_id_en); end
        total++; if (if_a.if_id_flush !== 1'b1 || if_a.id_ex_flush !== 1'b1 || if_a.id_ex_en !== 1'b1) begin bad++; $display("FAIL br_flush: got %b %b %b want 1 1 1", if_a.if_id_flush, if_a.id_ex_flush, if_a.id_ex_en); end
        @(negedge cpu_clk);
        drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); #1;
        total++; if (if_a.stall_cnt !== 32'd2 || if_a.if_id_flush !== 1'b0) begin bad++; $display("FAIL br_after: got cnt=%0d flush=%b want 2 0", if_a.stall_cnt, if_a.if_id_flush); end
    endtask

    task automatic test_bus_wait();
        for (int k = 0; k < 4; k++) begin
            @(negedge cpu_clk);
            drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, (k == 1), 1'b1, (k == 3)); #1;
            total++; if (if_a.bus_req !== 1'b1 || if_a.bus_err !== 1'b0) begin bad++; $display("FAIL bw_req_%0d: got req=%b err=%b want 1 0", k, if_a.bus_req, if_a.bus_err); end
            total++; if (if_a.pc_en !== (k == 3) || if_a.ex_mem_en !== (k == 3) || if_a.mem_wb_flush !== (k != 3)) begin bad++; $display("FAIL bw_ctl_%0d: got pc=%b exm=%b mwf=%b want %b %b %b", k, if_a.pc_en, if_a.ex_mem_en, if_a.mem_wb_flush, (k == 3), (k == 3), (k != 3)); end
            total++; if (if_a.if_id_flush !== 1'b0) begin bad++; $display("FAIL bw_no_br_%0d: got %b want 0", k, if_a.if_id_flush); end
        end
        @(negedge cpu_clk);
        drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); #1;
        total++; if (if_a.stall_cnt !== 32'd5 || if_a.bus_req !== 1'b0 || if_a.pc_en !== 1'b1) begin bad++; $display("FAIL bw_after: got cnt=%0d req=%b pc=%b want 5 0 1", if_a.stall_cnt, if_a.bus_req, if_a.pc_en); end
    endtask

    task automatic test_timeout();
        for (int k = 0; k < 5; k++) begin
            @(negedge cpu_clk);
            drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); #1;
            total++; if (if_b.bus_err !== (k == 4) || if_b.pc_en !== (k == 4) || if_b.bus_req !== 1'b1) begin bad++; $display("FAIL to_%0d: got err=%b pc=%b req=%b want %b %b 1", k, if_b.bus_err, if_b.pc_en, if_b.bus_req, (k == 4), (k == 4)); end
        end
        @(negedge cpu_clk);
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); #1;
        total++; if (if_b.bus_err !== 1'b0 || if_b.pc_en !== 1'b1 || if_b.ex_mem_en !== 1'b1 || if_b.id_ex_en !== 1'b1) begin bad++; $display("FAIL to_after: got err=%b pc=%b exm=%b idex=%b want 0 1 1 1", if_b.bus_err, if_b.pc_en, if_b.ex_mem_en, if_b.id_ex_en); end
        total++; if (if_b.stall_cnt !== 32'd4) begin bad++; $display("FAIL to_stall_cnt: got %0d want 4", if_b.stall_cnt); end
    endtask

    task automatic test_lu_stall3_bus();
        @(negedge cpu_clk);
        drive(1'b1, 5'd5, 5'd1, 2'b01, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); #1;
        total++; if (if_b.pc_en !== 1'b0 || if_b.id_ex_flush !== 1'b1) begin bad++; $display("FAIL l3_c0: got pc=%b flush=%b want 0 1", if_b.pc_en, if_b.id_ex_flush); end
        @(negedge cpu_clk);
        drive(1'b1, 5'd5, 5'd1, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); #1;
        total++; if (if_b.pc_en !== 1'b0 || if_b.id_ex_flush !== 1'b1 || if_b.bus_req !== 1'b1) begin bad++; $display("FAIL l3_c1: got pc=%b flush=%b req=%b want 0 1 1", if_b.pc_en, if_b.id_ex_flush, if_b.bus_req); end
        for (int k = 2; k < 4; k++) begin
            @(negedge cpu_clk);
            drive(1'b1, 5'd5, 5'd1, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); #1;
            total++; if (if_b.pc_en !== 1'b0 || if_b.mem_wb_flush !== 1'b1 || if_b.ex_mem_en !== 1'b0) begin bad++; $display("FAIL l3_c%0d: got pc=%b mwf=%b exm=%b want 0 1 0", k, if_b.pc_en, if_b.mem_wb_flush, if_b.ex_mem_en); end
        end
        @(negedge cpu_clk);
        drive(1'b1, 5'd5, 5'd1, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); #1;
        total++; if (if_b.bus_req !== 1'b1 || if_b.mem_wb_flush !== 1'b0 || if_b.bus_err !== 1'b0) begin bad++; $display("FAIL l3_rel: got req=%b mwf=%b err=%b want 1 0 0", if_b.bus_req, if_b.mem_wb_flush, if_b.bus_err); end
        for (int k = 0; k < 3; k++) begin
            @(negedge cpu_clk);
            drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        #1;
        total++; if (if_b.stall_cnt !== 32'd9 || if_b.pc_en !== 1'b1) begin bad++; $display("FAIL l3_total: got cnt=%0d pc=%b want 9 1", if_b.stall_cnt, if_b.pc_en); end
    endtask

    task automatic test_reset_mid_bus();
        for (int k = 0; k < 4; k++) begin
            @(negedge cpu_clk);
            drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        #1;
        total++; if (if_b.pc_en !== 1'b0 || if_b.bus_err !== 1'b0) begin bad++; $display("FAIL rm_wait: got pc=%b err=%b want 0 0", if_b.pc_en, if_b.bus_err); end
        @(negedge cpu_clk);
        rst_b = 1'b1; #1;
        total++; if (if_b.bus_req !== 1'b0 || if_b.pc_en !== 1'b1 || if_b.mem_wb_flush !== 1'b0 || if_b.bus_err !== 1'b0) begin bad++; $display("FAIL rm_outputs: got req=%b pc=%b mwf=%b err=%b want 0 1 0 0", if_b.bus_req, if_b.pc_en, if_b.mem_wb_flush, if_b.bus_err); end
        total++; if (if_b.stall_cnt !== 32'd0) begin bad++; $display("FAIL rm_stall_cnt: got %0d want 0", if_b.stall_cnt); end
        @(negedge cpu_clk);
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        rst_b = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge cpu_clk);
            drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); #1;
            total++; if (if_b.bus_err !== (k == 4)) begin bad++; $display("FAIL rm_timer_%0d: got err=%b want %b", k, if_b.bus_err, (k == 4)); end
        end
        @(negedge cpu_clk);
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); #1;
        total++; if (if_b.stall_cnt !== 32'd4) begin bad++; $display("FAIL rm_after_cnt: got %0d want 4", if_b.stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_bus_wait();
        test_timeout();
        test_lu_stall3_bus();
        test_reset_mid_bus();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
